// File: rtl/adma_desc_pkg.sv
// Shared types and helpers for the linked-list descriptor queue: field
// order/offsets inside a packed descriptor word, pack/unpack helpers and
// the controller state encoding.
package adma_desc_pkg;

  localparam int MAX_FIELD_W = 64;
  localparam int NUM_FIELDS  = 6;
  localparam int MAX_DESC_W  = NUM_FIELDS * MAX_FIELD_W;

  typedef logic [MAX_FIELD_W-1:0] field_t;
  typedef logic [MAX_DESC_W-1:0]  desc_word_t;

  // Fields are packed LSB first in this order.
  typedef enum logic [2:0] {
    FLD_SRC, FLD_DST, FLD_XLEN, FLD_YLEN, FLD_SRC_STRIDE, FLD_DST_STRIDE
  } desc_field_e;

  typedef enum logic {ST_INIT, ST_RUN} llq_state_e;

  function automatic int desc_w(int sa_w, int da_w, int len_w);
    return sa_w + da_w + 4 * len_w;
  endfunction

  function automatic int desc_off(desc_field_e f, int sa_w, int da_w, int len_w);
    case (f)
      FLD_SRC:        return 0;
      FLD_DST:        return sa_w;
      FLD_XLEN:       return sa_w + da_w;
      FLD_YLEN:       return sa_w + da_w + len_w;
      FLD_SRC_STRIDE: return sa_w + da_w + 2 * len_w;
      default:        return sa_w + da_w + 3 * len_w;
    endcase
  endfunction

  function automatic field_t field_mask(int w);
    return ~({MAX_FIELD_W{1'b1}} << w);
  endfunction

  function automatic desc_word_t desc_pack(field_t src, field_t dst, field_t xlen,
                                           field_t ylen, field_t sstr, field_t dstr,
                                           int sa_w, int da_w, int len_w);
    desc_word_t r;
    r  = desc_word_t'(src & field_mask(sa_w));
    r |= desc_word_t'(dst  & field_mask(da_w))  << desc_off(FLD_DST, sa_w, da_w, len_w);
    r |= desc_word_t'(xlen & field_mask(len_w)) << desc_off(FLD_XLEN, sa_w, da_w, len_w);
    r |= desc_word_t'(ylen & field_mask(len_w)) << desc_off(FLD_YLEN, sa_w, da_w, len_w);
    r |= desc_word_t'(sstr & field_mask(len_w)) << desc_off(FLD_SRC_STRIDE, sa_w, da_w, len_w);
    r |= desc_word_t'(dstr & field_mask(len_w)) << desc_off(FLD_DST_STRIDE, sa_w, da_w, len_w);
    return r;
  endfunction

  function automatic field_t desc_unpack(desc_word_t v, desc_field_e f,
                                         int sa_w, int da_w, int len_w);
    int w;
    case (f)
      FLD_SRC: w = sa_w;
      FLD_DST: w = da_w;
      default: w = len_w;
    endcase
    return field_t'(v >> desc_off(f, sa_w, da_w, len_w)) & field_mask(w);
  endfunction

endpackage

// File: rtl/adma_desc_llq_if.sv
// Push (register map) and pop (channel management) handshake bundle of the
// descriptor queue. master = surrounding logic, slave = the queue.
interface adma_desc_llq_if #(
  parameter int DMA_CHN_NUM  = 4,
  parameter int SRC_ADDR_W   = 32,
  parameter int DST_ADDR_W   = 32,
  parameter int DMA_LENGTH_W = 16
);
  localparam int CHN_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1;

  logic [SRC_ADDR_W-1:0]   src_addr_i   [DMA_CHN_NUM];
  logic [DST_ADDR_W-1:0]   dst_addr_i   [DMA_CHN_NUM];
  logic [DMA_LENGTH_W-1:0] xfer_xlen_i  [DMA_CHN_NUM];
  logic [DMA_LENGTH_W-1:0] xfer_ylen_i  [DMA_CHN_NUM];
  logic [DMA_LENGTH_W-1:0] src_stride_i [DMA_CHN_NUM];
  logic [DMA_LENGTH_W-1:0] dst_stride_i [DMA_CHN_NUM];
  logic [DMA_CHN_NUM-1:0]  desc_wr_vld_i;
  logic [DMA_CHN_NUM-1:0]  desc_wr_rdy_o;
  logic [DMA_CHN_NUM-1:0]  desc_rd_req_i;
  logic [DMA_CHN_NUM-1:0]  desc_rd_gnt_o;
  logic [SRC_ADDR_W-1:0]   src_addr_o;
  logic [DST_ADDR_W-1:0]   dst_addr_o;
  logic [DMA_LENGTH_W-1:0] xfer_xlen_o;
  logic [DMA_LENGTH_W-1:0] xfer_ylen_o;
  logic [DMA_LENGTH_W-1:0] src_stride_o;
  logic [DMA_LENGTH_W-1:0] dst_stride_o;
  logic [CHN_W-1:0]        desc_rd_chn_o;
  logic                    desc_rd_vld_o;
  logic                    desc_rd_rdy_i;

  modport master (
    output src_addr_i, dst_addr_i, xfer_xlen_i, xfer_ylen_i, src_stride_i, dst_stride_i,
    output desc_wr_vld_i, desc_rd_req_i, desc_rd_rdy_i,
    input  desc_wr_rdy_o, desc_rd_gnt_o, src_addr_o, dst_addr_o, xfer_xlen_o,
    input  xfer_ylen_o, src_stride_o, dst_stride_o, desc_rd_chn_o, desc_rd_vld_o
  );

  modport slave (
    input  src_addr_i, dst_addr_i, xfer_xlen_i, xfer_ylen_i, src_stride_i, dst_stride_i,
    input  desc_wr_vld_i, desc_rd_req_i, desc_rd_rdy_i,
    output desc_wr_rdy_o, desc_rd_gnt_o, src_addr_o, dst_addr_o, xfer_xlen_o,
    output xfer_ylen_o, src_stride_o, dst_stride_o, desc_rd_chn_o, desc_rd_vld_o
  );

endinterface

// File: rtl/adma_rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant, pointer moves to
// the slot after the winner whenever a grant is issued.
module adma_rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [PW-1:0] win
);

  logic [PW-1:0] ptr_q;

  // First requester at or after the pointer wins.
  always_comb begin
    gnt = '0;
    win = ptr_q;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % N;
      if (gnt == '0 && req[idx]) begin
        gnt[idx] = 1'b1;
        win      = PW'(idx);
      end
    end
  end

  // Advance priority past the winner.
  always_ff @(posedge clk) begin
    if (rst)        ptr_q <= '0;
    else if (|gnt)  ptr_q <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
  end

endmodule

// File: rtl/adma_desc_llq.sv
// Shared-pool linked-list descriptor queue. All channels allocate slots of
// one descriptor RAM from a free FIFO; each channel keeps head/tail/count
// and slots are chained through next[].
//
// state   | meaning
// INIT    | walking the free FIFO, writing slot index i into entry i
// RUN     | normal push/pop operation, left only on reset
module adma_desc_llq import adma_desc_pkg::*; #(
  parameter  int DMA_CHN_NUM    = 4,
  parameter  int POOL_DEPTH     = 16,
  parameter  int CHN_DESC_DEPTH = 8,
  parameter  int SRC_ADDR_W     = 32,
  parameter  int DST_ADDR_W     = 32,
  parameter  int DMA_LENGTH_W   = 16,
  localparam int CNT_W  = $clog2(CHN_DESC_DEPTH + 1),
  localparam int FREE_W = $clog2(POOL_DEPTH + 1),
  localparam int SLOT_W = $clog2(POOL_DEPTH),
  localparam int CHN_W  = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1,
  localparam int DESC_W = desc_w(SRC_ADDR_W, DST_ADDR_W, DMA_LENGTH_W)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               queue_en_i,
  adma_desc_llq_if.slave                     bus,
  output logic [DMA_CHN_NUM-1:0][CNT_W-1:0]  desc_cnt_o,
  output logic [FREE_W-1:0]                  free_cnt_o,
  output logic                               init_done_o
);

  llq_state_e        state_q;
  logic [SLOT_W-1:0] init_cnt_q, free_rd_q, free_wr_q;
  logic [SLOT_W-1:0] free_fifo_q [POOL_DEPTH];
  logic [SLOT_W-1:0] next_q      [POOL_DEPTH];
  logic [DESC_W-1:0] ram_q       [POOL_DEPTH];
  logic [SLOT_W-1:0] head_q [DMA_CHN_NUM];
  logic [SLOT_W-1:0] tail_q [DMA_CHN_NUM];
  logic [CNT_W-1:0]  cnt_q  [DMA_CHN_NUM];
  logic [FREE_W-1:0] free_cnt_q;
  logic [DESC_W-1:0] rd_word_q;
  logic [CHN_W-1:0]  rd_chn_q;
  logic              rd_vld_q, init_done_q;

  logic                   run, push_any, pop_any;
  logic [DMA_CHN_NUM-1:0] push_req, pop_req, push_gnt, pop_gnt;
  logic [CHN_W-1:0]       push_win, pop_win;
  logic [SLOT_W-1:0]      alloc_slot, pop_slot;
  logic [DESC_W-1:0]      wr_word;

  assign run = (state_q == ST_RUN);

  // Per-channel eligibility; a pop needs room in the output register.
  always_comb begin
    for (int c = 0; c < DMA_CHN_NUM; c++) begin
      push_req[c] = run && queue_en_i && bus.desc_wr_vld_i[c] &&
                    (cnt_q[c] < CNT_W'(CHN_DESC_DEPTH)) && (free_cnt_q != '0);
      pop_req[c]  = run && queue_en_i && bus.desc_rd_req_i[c] && (cnt_q[c] != '0) &&
                    (!rd_vld_q || bus.desc_rd_rdy_i);
    end
  end

  adma_rr_arbiter #(.N(DMA_CHN_NUM)) u_push_arb (
    .clk(clk), .rst(rst), .req(push_req), .gnt(push_gnt), .win(push_win));
  adma_rr_arbiter #(.N(DMA_CHN_NUM)) u_pop_arb (
    .clk(clk), .rst(rst), .req(pop_req), .gnt(pop_gnt), .win(pop_win));

  assign push_any   = |push_gnt;
  assign pop_any    = |pop_gnt;
  assign alloc_slot = free_fifo_q[free_rd_q];
  assign pop_slot   = head_q[pop_win];
  assign wr_word    = DESC_W'(desc_pack(field_t'(bus.src_addr_i[push_win]),
                                        field_t'(bus.dst_addr_i[push_win]),
                                        field_t'(bus.xfer_xlen_i[push_win]),
                                        field_t'(bus.xfer_ylen_i[push_win]),
                                        field_t'(bus.src_stride_i[push_win]),
                                        field_t'(bus.dst_stride_i[push_win]),
                                        SRC_ADDR_W, DST_ADDR_W, DMA_LENGTH_W));

  // Controller state, list pointers, counters and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      free_rd_q   <= '0;
      free_wr_q   <= '0;
      free_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rd_word_q   <= '0;
      rd_chn_q    <= '0;
      rd_vld_q    <= 1'b0;
      for (int c = 0; c < DMA_CHN_NUM; c++) begin
        head_q[c] <= '0;
        tail_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else if (state_q == ST_INIT) begin
      init_cnt_q <= init_cnt_q + SLOT_W'(1);
      if (init_cnt_q == SLOT_W'(POOL_DEPTH - 1)) begin
        state_q     <= ST_RUN;
        free_cnt_q  <= FREE_W'(POOL_DEPTH);
        init_done_q <= 1'b1;
      end
    end else begin
      for (int c = 0; c < DMA_CHN_NUM; c++) begin
        if (push_gnt[c]) tail_q[c] <= alloc_slot;
        if (push_gnt[c] && cnt_q[c] == '0)
          head_q[c] <= alloc_slot;
        else if (pop_gnt[c])
          // Popping the last entry while appending: next[] of the old head is not written yet.
          head_q[c] <= (push_gnt[c] && cnt_q[c] == CNT_W'(1)) ? alloc_slot : next_q[head_q[c]];
        if (push_gnt[c] && !pop_gnt[c])      cnt_q[c] <= cnt_q[c] + CNT_W'(1);
        else if (pop_gnt[c] && !push_gnt[c]) cnt_q[c] <= cnt_q[c] - CNT_W'(1);
      end
      if (push_any) free_rd_q <= free_rd_q + SLOT_W'(1);
      if (pop_any)  free_wr_q <= free_wr_q + SLOT_W'(1);
      free_cnt_q <= free_cnt_q + FREE_W'(pop_any) - FREE_W'(push_any);
      if (pop_any) begin
        rd_word_q <= ram_q[pop_slot];
        rd_chn_q  <= pop_win;
        rd_vld_q  <= 1'b1;
      end else if (bus.desc_rd_rdy_i) begin
        rd_vld_q  <= 1'b0;
      end
    end
  end

  // Free FIFO: filled with every slot index during INIT, then recycles popped slots.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) free_fifo_q[init_cnt_q] <= init_cnt_q;
    else if (pop_any)       free_fifo_q[free_wr_q]  <= pop_slot;
  end

  // Link the new slot behind the current tail of a non-empty channel.
  always_ff @(posedge clk) begin
    if (push_any && cnt_q[push_win] != '0) next_q[tail_q[push_win]] <= alloc_slot;
  end

  // Descriptor RAM write port.
  always_ff @(posedge clk) begin
    if (push_any) ram_q[alloc_slot] <= wr_word;
  end

  // Per-channel occupancy view.
  always_comb begin
    for (int c = 0; c < DMA_CHN_NUM; c++) desc_cnt_o[c] = cnt_q[c];
  end

  assign free_cnt_o        = free_cnt_q;
  assign init_done_o       = init_done_q;
  assign bus.desc_wr_rdy_o = push_gnt;
  assign bus.desc_rd_gnt_o = pop_gnt;
  assign bus.desc_rd_vld_o = rd_vld_q;
  assign bus.desc_rd_chn_o = rd_chn_q;
  assign bus.src_addr_o    = SRC_ADDR_W'(desc_unpack(desc_word_t'(rd_word_q), FLD_SRC,
                                                     SRC_ADDR_W, DST_ADDR_W, DMA_LENGTH_W));
  assign bus.dst_addr_o    = DST_ADDR_W'(desc_unpack(desc_word_t'(rd_word_q), FLD_DST,
                                                     SRC_ADDR_W, DST_ADDR_W, DMA_LENGTH_W));
  assign bus.xfer_xlen_o   = DMA_LENGTH_W'(desc_unpack(desc_word_t'(rd_word_q), FLD_XLEN,
                                                       SRC_ADDR_W, DST_ADDR_W, DMA_LENGTH_W));
  assign bus.xfer_ylen_o   = DMA_LENGTH_W'(desc_unpack(desc_word_t'(rd_word_q), FLD_YLEN,
                                                       SRC_ADDR_W, DST_ADDR_W, DMA_LENGTH_W));
  assign bus.src_stride_o  = DMA_LENGTH_W'(desc_unpack(desc_word_t'(rd_word_q), FLD_SRC_STRIDE,
                                                       SRC_ADDR_W, DST_ADDR_W, DMA_LENGTH_W));
  assign bus.dst_stride_o  = DMA_LENGTH_W'(desc_unpack(desc_word_t'(rd_word_q), FLD_DST_STRIDE,
                                                       SRC_ADDR_W, DST_ADDR_W, DMA_LENGTH_W));

endmodule

// File: doc/adma_desc_llq.md
Name: adma_desc_llq

Overview:
- Shared-pool, linked-list descriptor queue for the DMA write channels.
- Successor to the per-channel flip-flop queue: all channels share one descriptor data RAM of POOL_DEPTH entries.
- Each channel has a per-channel depth cap, with round-robin arbitration on both push and pop.
- Sits between the register map (push side) and channel management (pop side), and delivers one descriptor per cycle on a single tagged output.

Parameters:
- DMA_CHN_NUM, 4, number of DMA channels (≥2).
- POOL_DEPTH, 16, total shared descriptor slots (power of 2, ≥ DMA_CHN_NUM).
- CHN_DESC_DEPTH, 8, max descriptors held per channel (≤ POOL_DEPTH).
- SRC_ADDR_W, 32, source address width.
- DST_ADDR_W, 32, destination address width.
- DMA_LENGTH_W, 16, width of xlen/ylen/src_stride/dst_stride.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- queue_en_i  in  1  0 = no new push or pop grants; state is held.
- src_addr_i/dst_addr_i/xfer_xlen_i/xfer_ylen_i/src_stride_i/dst_stride_i  in  field width x[DMA_CHN_NUM]  push descriptor fields.
- desc_wr_vld_i  in  1x[DMA_CHN_NUM]  push request.
- desc_wr_rdy_o  out  1x[DMA_CHN_NUM]  push accepted this cycle (one-hot or zero).
- desc_rd_req_i  in  1x[DMA_CHN_NUM]  channel requests its next descriptor (level).
- desc_rd_gnt_o  out  1x[DMA_CHN_NUM]  one-cycle pop grant (one-hot or zero).
- src_addr_o/dst_addr_o/xfer_xlen_o/xfer_ylen_o/src_stride_o/dst_stride_o  out  field width  popped descriptor.
- desc_rd_chn_o  out  $clog2(DMA_CHN_NUM)  owner channel of the output descriptor.
- desc_rd_vld_o  out  1  output register valid.
- desc_rd_rdy_i  in  1  consumer accepts the output.
- desc_cnt_o  out  $clog2(CHN_DESC_DEPTH+1)x[DMA_CHN_NUM]  per-channel occupancy.
- free_cnt_o  out  $clog2(POOL_DEPTH+1)  free slots.
- init_done_o  out  1  free list initialised.

Behaviour:
- Reset values: all outputs 0.
- Reset clears every head/tail/count.
- Reset enters INIT, including when asserted mid-operation; in-flight descriptors are discarded.
- FSM INIT: counter i = 0..POOL_DEPTH-1 writes free_fifo[i] = i, one entry per cycle.
- After POOL_DEPTH cycles: free_cnt = POOL_DEPTH, init_done_o = 1, state → RUN. RUN is left only on reset.
- In INIT all rdy/gnt outputs are 0.
- Push eligibility for channel c:
  - RUN, queue_en_i, desc_wr_vld_i[c], desc_cnt[c] < CHN_DESC_DEPTH, free_cnt > 0.
  - A round-robin arbiter picks one eligible channel; desc_wr_rdy_o[c] is combinational from the arbiter.
  - The pointer advances past the winner on grant.
- Push of channel c:
  - Slot a = free_fifo head.
  - data[a] ← packed descriptor.
  - If cnt[c] == 0: head[c] ← a; else next[tail[c]] ← a.
  - tail[c] ← a; cnt[c]++; free_cnt--.
- Pop eligibility for channel c:
  - RUN, queue_en_i, desc_rd_req_i[c], cnt[c] > 0, and (!desc_rd_vld_o || desc_rd_rdy_i).
  - An independent round-robin arbiter issues a one-cycle desc_rd_gnt_o[c].
- Pop of channel c:
  - Synchronous RAM read of data[head[c]]; the output register loads next cycle.
  - Latency: grant at cycle N → desc_rd_vld_o = 1 with data at N+1.
  - Freed slot pushed to free_fifo tail; head[c] ← next[head[c]]; cnt[c]--.
- Output register holds while desc_rd_vld_o && !desc_rd_rdy_i. With back-to-back grants and rdy held high, throughput is 1 descriptor/cycle.
- Simultaneous push and pop:
  - Both allowed in the same cycle, on the same or different channels.
  - free_cnt changes by (free − alloc).
  - Same channel with cnt == 1: head[c] ← a (the new slot); tail[c] ← a; cnt unchanged.
  - Same channel with cnt == 0: no pop.
  - With free_cnt == 0, a same-cycle free does not enable a push; there is no bypass.
- Arrays:
  - The data RAM has one write port and one read port; push and pop never address the same slot.
  - The next[] pointer array and free_fifo are flip-flop based.
- Ordering: strict FIFO per channel; no ordering guarantee across channels.
- queue_en_i low: no grants; an occupied output register still drains via desc_rd_rdy_i.

Decomposition:
- adma_desc_pkg holds:
  - descriptor field order/offsets;
  - the DESC_W function of the widths;
  - pack/unpack functions;
  - state enum {INIT, RUN}.
- Sub-module adma_rr_arbiter (N-way round-robin, req → one-hot gnt, advance on accept), instantiated twice.

Test Plan:
- Reset, then idle: init_done_o rises exactly 16 cycles after rst deassert; free_cnt_o = 16; every rdy = 0 during INIT.
- Channel 0 pushes 8 descriptors with src_addr 0x1000 + 0x100·k → rdy drops on the 9th while free_cnt_o = 8. Pop returns 0x1000..0x1700 in order, each 1 cycle after grant.
- Channels 0-3 push continuously → grants rotate 0, 1, 2, 3, 0… until free_cnt_o = 0. Then all rdy = 0 although every desc_cnt < 8.
- Channel 2 at cnt = 1: push and pop in the same cycle → output is the old descriptor, cnt stays 1, and the next pop returns the new one.
- Hold desc_rd_rdy_i = 0 with a valid output → no further gnt; output stable. Release → one transfer per cycle.
- Assert rst mid-traffic with 10 slots used → next cycle all counts 0 and vld 0, INIT rewalks, free_cnt_o returns to 16.
